// File: rtl/mbist_alg_sequencer.sv
// MBIST algorithm sequencer: runs each selected algorithm on the MBIST top block in ascending order,
// gathers per-algorithm fail/timeout bits and reports one pass/fail verdict.
module mbist_alg_sequencer #(
   parameter int ASNET = 3,
   parameter int TOW   = 20,
   parameter int GAP   = 2
) (
   input  logic             TCLK,
   input  logic             RESET_H,
   input  logic             START,
   input  logic             ABORT,
   input  logic [ASNET:0]   ALG_MASK,
   input  logic             BIST_FAIL,
   input  logic             BIST_DONE,
   output logic             TEST_H,
   output logic [ASNET:0]   ALG_SEL,
   output logic             BUSY,
   output logic             RESULT_VALID,
   output logic [ASNET:0]   FAIL_MAP,
   output logic [ASNET:0]   TIMEOUT_MAP,
   output logic             ALL_PASS
);

   localparam int AW = ASNET + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
   localparam logic [TOW-1:0] WD_MAX   = {TOW{1'b1}};
   localparam logic [GW-1:0]  GAP_LAST = GW'(GAP - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SCAN   = 3'd1,
      ST_ARM    = 3'd2,
      ST_RUN    = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_REPORT = 3'd5
   } state_t;

   state_t           state_r;
   logic [AW-1:0]    pend_r;
   logic             acc_r;
   logic [TOW-1:0]   wd_r;
   logic [GW-1:0]    gap_r;
   logic [AW-1:0]    sel_s;
   logic [TOW-1:0]   wd_inc_s;
   logic             wd_hit_s;

   // Isolate the lowest set bit of a vector as a one-hot value.
   function automatic logic [AW-1:0] lowest_onehot(input logic [AW-1:0] v);
      return v & (~v + {{(AW-1){1'b0}}, 1'b1});
   endfunction

   // The watchdog fires on the cycle whose count reaches all-ones.
   assign sel_s    = lowest_onehot(pend_r);
   assign wd_inc_s = wd_r + {{(TOW-1){1'b0}}, 1'b1};
   assign wd_hit_s = (wd_inc_s == WD_MAX);

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge TCLK or posedge RESET_H) begin
      if (RESET_H) begin
         state_r      <= ST_IDLE;
         pend_r       <= {AW{1'b0}};
         acc_r        <= 1'b0;
         wd_r         <= {TOW{1'b0}};
         gap_r        <= {GW{1'b0}};
         TEST_H       <= 1'b0;
         ALG_SEL      <= {AW{1'b0}};
         BUSY         <= 1'b0;
         RESULT_VALID <= 1'b0;
         FAIL_MAP     <= {AW{1'b0}};
         TIMEOUT_MAP  <= {AW{1'b0}};
         ALL_PASS     <= 1'b0;
      end else begin
         RESULT_VALID <= 1'b0;
         if (ABORT && (state_r != ST_IDLE)) begin
            state_r <= ST_IDLE;
            TEST_H  <= 1'b0;
            ALG_SEL <= {AW{1'b0}};
            BUSY    <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (START) begin
                     pend_r      <= ALG_MASK;
                     FAIL_MAP    <= {AW{1'b0}};
                     TIMEOUT_MAP <= {AW{1'b0}};
                     ALL_PASS    <= 1'b0;
                     BUSY        <= 1'b1;
                     state_r     <= ST_SCAN;
                  end
               end
               ST_SCAN: begin
                  if (pend_r == {AW{1'b0}}) begin
                     RESULT_VALID <= 1'b1;
                     ALL_PASS     <= ~|FAIL_MAP;
                     state_r      <= ST_REPORT;
                  end else begin
                     ALG_SEL <= sel_s;
                     pend_r  <= pend_r & ~sel_s;
                     acc_r   <= 1'b0;
                     wd_r    <= {TOW{1'b0}};
                     state_r <= ST_ARM;
                  end
               end
               ST_ARM: begin
                  TEST_H  <= 1'b1;
                  state_r <= ST_RUN;
               end
               ST_RUN: begin
                  acc_r <= acc_r | BIST_FAIL;
                  wd_r  <= wd_inc_s;
                  if (BIST_DONE) begin
                     if (acc_r | BIST_FAIL) begin
                        FAIL_MAP <= FAIL_MAP | ALG_SEL;
                     end
                     TEST_H  <= 1'b0;
                     gap_r   <= {GW{1'b0}};
                     wd_r    <= {TOW{1'b0}};
                     state_r <= ST_DRAIN;
                  end else if (wd_hit_s) begin
                     FAIL_MAP    <= FAIL_MAP | ALG_SEL;
                     TIMEOUT_MAP <= TIMEOUT_MAP | ALG_SEL;
                     TEST_H      <= 1'b0;
                     gap_r       <= {GW{1'b0}};
                     wd_r        <= {TOW{1'b0}};
                     state_r     <= ST_DRAIN;
                  end
               end
               ST_DRAIN: begin
                  // Here the watchdog counts consecutive cycles of DONE stuck high.
                  if ((gap_r == GAP_LAST) && !BIST_DONE) begin
                     ALG_SEL <= {AW{1'b0}};
                     state_r <= ST_SCAN;
                  end else if (BIST_DONE && wd_hit_s) begin
                     FAIL_MAP    <= FAIL_MAP | ALG_SEL;
                     TIMEOUT_MAP <= TIMEOUT_MAP | ALG_SEL;
                     ALG_SEL     <= {AW{1'b0}};
                     state_r     <= ST_SCAN;
                  end else begin
                     if (gap_r != GAP_LAST) begin
                        gap_r <= gap_r + {{(GW-1){1'b0}}, 1'b1};
                     end
                     wd_r <= BIST_DONE ? wd_inc_s : {TOW{1'b0}};
                  end
               end
               ST_REPORT: begin
                  BUSY    <= 1'b0;
                  state_r <= ST_IDLE;
               end
               default: begin
                  state_r <= ST_IDLE;
                  TEST_H  <= 1'b0;
                  ALG_SEL <= {AW{1'b0}};
                  BUSY    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
